// File: rtl/calc_pkg.sv
// Shared types, segment constants and the double-dabble step for the
// calculator result display.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    localparam int CONV_ITER = 8;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    // One double-dabble iteration on {bcd[11:0], bin[7:0]}:
    // correct every BCD nibble that would overflow on doubling, then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] sr);
        logic [19:0] t;
        t = sr;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5)
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/result_display_if.sv
// Handshake between the arithmetic unit and the result display, plus the
// display outputs toward the board HEX digits and LEDs.
interface result_display_if;
    logic       valid;
    logic [7:0] value;
    logic       add_sub_overflow;
    logic [1:0] mult_div_overflow;
    logic       busy;
    logic       done;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic       dp0;
    logic       dp1;
    logic       ovf_led;

    // Producer side (arithmetic unit / testbench)
    modport master (
        output valid, value, add_sub_overflow, mult_div_overflow,
        input  busy, done, hex0, hex1, hex2, dp0, dp1, ovf_led
    );

    // Display side
    modport slave (
        input  valid, value, add_sub_overflow, mult_div_overflow,
        output busy, done, hex0, hex1, hex2, dp0, dp1, ovf_led
    );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Codes 10-15 never reach here from a valid conversion and show blank.
module seg7_decoder
    import calc_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    // Digit lookup, blank for non-decimal codes
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// Captures an 8-bit result plus overflow flags, converts it to three BCD
// digits over eight double-dabble cycles and registers the HEX/LED outputs.
// One result every 10 cycles; valid arriving while busy is dropped.
module result_display
    import calc_pkg::*;
#(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    result_display_if.slave  bus
);

    state_t      r_state;
    state_t      w_next;
    logic [19:0] r_sr;
    logic [2:0]  r_cnt;
    logic        r_asf;
    logic [1:0]  r_mdf;
    logic [6:0]  r_hex0;
    logic [6:0]  r_hex1;
    logic [6:0]  r_hex2;
    logic        r_dp0;
    logic        r_dp1;
    logic        r_ovf;
    logic        r_done;

    logic        w_capture;
    logic        w_step;
    logic        w_load;
    logic [3:0]  w_ones;
    logic [3:0]  w_tens;
    logic [3:0]  w_hund;
    logic [6:0]  w_seg_o;
    logic [6:0]  w_seg_t;
    logic [6:0]  w_seg_h;
    logic        w_blank_h;
    logic        w_blank_t;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state and datapath strobes
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_step    = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.valid) begin
                    w_capture = 1'b1;
                    w_next    = CONVERT;
                end
            end
            CONVERT: begin
                w_step = 1'b1;
                if (r_cnt == 3'(CONV_ITER - 1)) w_next = UPDATE;
            end
            UPDATE: begin
                w_load = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture inputs and run the shift-add-3 iterations
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
            r_asf <= 1'b0;
            r_mdf <= '0;
        end else if (w_capture) begin
            r_sr  <= {12'd0, bus.value};
            r_cnt <= '0;
            r_asf <= bus.add_sub_overflow;
            r_mdf <= bus.mult_div_overflow;
        end else if (w_step) begin
            r_sr  <= dd_step(r_sr);
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign w_ones = r_sr[11:8];
    assign w_tens = r_sr[15:12];
    assign w_hund = r_sr[19:16];

    seg7_decoder u_dec_o (.i_digit(w_ones), .o_seg(w_seg_o));
    seg7_decoder u_dec_t (.i_digit(w_tens), .o_seg(w_seg_t));
    seg7_decoder u_dec_h (.i_digit(w_hund), .o_seg(w_seg_h));

    // Leading-zero suppression; the ones digit always shows
    assign w_blank_h = BLANK_LEADING && (w_hund == 4'd0);
    assign w_blank_t = BLANK_LEADING && (w_hund == 4'd0) && (w_tens == 4'd0);

    // Output registers update once per conversion; done marks that cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hex0 <= SEG_0;
            r_hex1 <= SEG_BLANK;
            r_hex2 <= SEG_BLANK;
            r_dp0  <= 1'b1;
            r_dp1  <= 1'b1;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_load) begin
                r_hex0 <= w_seg_o;
                r_hex1 <= w_blank_t ? SEG_BLANK : w_seg_t;
                r_hex2 <= w_blank_h ? SEG_BLANK : w_seg_h;
                r_dp0  <= ~r_mdf[0];
                r_dp1  <= ~r_mdf[1];
                r_ovf  <= r_asf;
            end
        end
    end

    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = r_done;
    assign bus.hex0    = r_hex0;
    assign bus.hex1    = r_hex1;
    assign bus.hex2    = r_hex2;
    assign bus.dp0     = r_dp0;
    assign bus.dp1     = r_dp1;
    assign bus.ovf_led = r_ovf;

endmodule

// File: doc/result_display.md
# result_display

Sequential result decoder for the 4-bit calculator datapath. It captures the 8-bit unsigned result and the overflow flags produced by the arithmetic unit. It converts the result to three BCD digits with an iterative shift-add-3 (double-dabble) engine, then drives three active-low seven-segment digits plus decimal points and an overflow LED. It sits between the arithmetic unit's outputs and the board HEX displays and LEDs.

## Interface
- BLANK_LEADING, default 1: 1 blanks leading-zero hundreds and tens digits; 0 shows all three digits.
- clk  in  1  system clock (50 MHz board clock)
- reset_n  in  1  synchronous, active-low reset
- valid  in  1  result present; sampled only in IDLE
- value  in  8  unsigned result from arithmetic unit (returnValue)
- add_sub_overflow  in  1  carry from add/subtract path
- mult_div_overflow  in  2  decimal-point flags from mult/div path
- busy  out  1  high while a conversion is in progress (state != IDLE)
- done  out  1  one-cycle pulse when display registers update
- hex0  out  7  ones digit, segments {g,f,e,d,c,b,a}, active-low
- hex1  out  7  tens digit, same encoding
- hex2  out  7  hundreds digit, same encoding
- dp0, dp1  out  1 each  decimal points of hex0/hex1, active-low
- ovf_led  out  1  active-high overflow LED

## Operation
- States: IDLE, CONVERT, UPDATE.
- IDLE: when valid=1, latch value into a 20-bit shift register {bcd[11:0], bin[7:0]} with bcd=0. Latch both flag inputs. Clear the iteration counter. Go to CONVERT.
- CONVERT: each cycle, add 3 to every BCD nibble that is ≥5, then shift the whole register left 1. The counter increments. After 8 iterations (counter==7), go to UPDATE.
- UPDATE: load the output registers from the bcd nibbles and latched flags. Pulse done. Return to IDLE.
- valid while busy is ignored; there is no queue. Inputs are sampled only at the IDLE capture edge, and later changes do not affect the conversion in flight.
- Segment decode covers digits 0-9 (a=bit0). Nibbles 10-15 cannot occur and decode to blank (7'h7F).
- Leading-zero blanking (BLANK_LEADING=1):
  - hex2 is blank if hundreds==0.
  - hex1 is blank if hundreds==0 and tens==0.
  - hex0 is always shown.
- dp0 = ~mult_div_overflow[0]; dp1 = ~mult_div_overflow[1]; ovf_led = add_sub_overflow. All three use the latched flags.
- Reset values: state IDLE, busy=0, done=0, hex0=7'h40 ("0"), hex1=hex2=7'h7F, dp0=dp1=1, ovf_led=0, shift register 0, counter 0.
- Reset asserted mid-conversion aborts the conversion. All outputs return to reset values on that edge, and the next valid after release starts a fresh conversion.

## Timing
- E0 = clock edge where IDLE samples valid=1.
- E1..E8 perform the 8 CONVERT iterations; the state is UPDATE after E8.
- At E9, outputs are registered and done=1 for the cycle following E9; the state returns to IDLE.
- Latency: outputs change 9 cycles after the capture edge.
- busy is high after E0 through E9, and low after E9.
- The earliest next capture is E10, giving a throughput of one result per 10 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.
- A valid held continuously re-captures at E10, E20, …, and each capture produces its own done pulse.

## Structure
- Shared package calc_pkg:
  - state enum {IDLE, CONVERT, UPDATE}
  - SEG_BLANK = 7'h7F
  - digit segment constants SEG_0..SEG_9
  - CONV_ITER = 8
- Sub-module seg7_decoder: combinational 4-bit to 7-bit active-low decoder, instantiated three times. Blanking muxes sit in result_display.
- The double-dabble step (conditional add-3 on three nibbles plus shift) is a function in calc_pkg.

## Test plan
- Reset, then valid with value=8'd255, ovf=0 → after E9: hex2=SEG_2, hex1=SEG_5, hex0=SEG_5, done one cycle, busy high E0–E9.
- value=8'd7, BLANK_LEADING=1 → hex2=hex1=7'h7F, hex0=SEG_7; with BLANK_LEADING=0 → hex2=hex1=SEG_0.
- value=8'd105 → hex2=SEG_1, hex1=SEG_0 (not blanked, hundreds≠0), hex0=SEG_5.
- value=8'd40, then a second valid with value=99 at E3 → the second is ignored and the display shows 040 (blanked as "40"). A third valid at E10 shows 99 after E19.
- value=8'd12 with add_sub_overflow=1, mult_div_overflow=2'b10 → ovf_led=1, dp1=0, dp0=1. Changing the flags at E2 has no effect on that result.
- value=8'd200, reset_n low at E4 → busy=0, done never pulses, hex0=7'h40, hex1=hex2=7'h7F. The next valid with 33 yields "33" after 9 cycles.
